// File: rtl/pc_stack_unit_pkg.sv
// Shared definitions for the MiniRISC program counter and return stack:
// default widths, reset/interrupt vectors, flag bit positions and the
// decoded operation type produced by the strobe priority decoder.
package pc_stack_unit_pkg;

  localparam int PC_WIDTH_DEF   = 8;
  localparam int FLAG_WIDTH_DEF = 6;

  localparam logic [7:0] RESET_VECTOR_DEF = 8'h00;
  localparam logic [7:0] INT_VECTOR_DEF   = 8'h01;

  // Bit positions inside the saved flag image {IF,IE,V,N,C,Z}; these follow
  // the controller's own flag ordering so the image can be restored verbatim.
  localparam int FLAG_Z  = 0;
  localparam int FLAG_C  = 1;
  localparam int FLAG_N  = 2;
  localparam int FLAG_V  = 3;
  localparam int FLAG_IE = 4;
  localparam int FLAG_IF = 5;

  // Single operation selected each cycle after strobe priority resolution.
  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_INIT  = 3'd1,
    OP_INT   = 3'd2,
    OP_CALL  = 3'd3,
    OP_RETI  = 3'd4,
    OP_RETS  = 3'd5,
    OP_JUMP  = 3'd6,
    OP_FETCH = 3'd7
  } op_e;

endpackage

// File: rtl/pc_stack_unit_lifo_stack.sv
// Return stack: register array with asynchronous read of the top entry and
// synchronous push/pop. Overflow and underflow leave the contents and the
// pointer untouched and raise a sticky error flag.
module lifo_stack #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             err
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int AW  = $clog2(DEPTH);

  logic [SPW-1:0]   sp_q, sp_d;
  logic             err_q, err_d;
  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign empty = (sp_q == '0);
  assign full  = (sp_q == SPW'(DEPTH));
  assign err   = err_q;

  // Pointer/error next-state and array addressing; push and pop are never
  // asserted together by the caller, so push is simply checked first.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    sp_d   = sp_q;
    err_d  = err_q;
    wr_en  = 1'b0;
    wr_idx = sp_q[AW-1:0];
    // While empty the read index is parked at 0; the top value is don't-care then.
    rd_idx = empty ? '0 : (sp_q[AW-1:0] - AW'(1));
    if (push) begin
      if (full) begin
        err_d = 1'b1;
      end else begin
        wr_en = !rst;
        sp_d  = sp_q + SPW'(1);
      end
    end else if (pop) begin
      if (empty) begin
        err_d = 1'b1;
      end else begin
        sp_d = sp_q - SPW'(1);
      end
    end
  end

  // Stack pointer and sticky error register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Entry storage written at the current pointer on an accepted push.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; entries are only read after being written.
    if (wr_en) begin
      mem_q[wr_idx] <= din;
    end
  end

  assign top = mem_q[rd_idx];

endmodule

// File: rtl/pc_stack_unit.sv
// MiniRISC program counter with hardware return stack. Resolves the
// controller strobes by fixed priority, drives the next-PC mux and pushes or
// pops {flags,pc} records on the return stack.
module pc_stack_unit
  import pc_stack_unit_pkg::*;
#(
  parameter int                    PC_WIDTH     = PC_WIDTH_DEF,
  parameter int                    FLAG_WIDTH   = FLAG_WIDTH_DEF,
  parameter int                    STACK_DEPTH  = 16,
  parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [PC_WIDTH-1:0]   INT_VECTOR   = INT_VECTOR_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  initialize,
  input  logic                  fetch,
  input  logic                  ex_jump,
  input  logic                  ex_call,
  input  logic                  ex_ret_sub,
  input  logic                  ex_ret_int,
  input  logic                  interrupt,
  input  logic [PC_WIDTH-1:0]   jump_addr,
  input  logic [FLAG_WIDTH-1:0] flags_in,
  output logic [PC_WIDTH-1:0]   pc,
  output logic [FLAG_WIDTH-1:0] flags_out,
  output logic                  stack_empty,
  output logic                  stack_full,
  output logic                  stack_err
);

  localparam int ENTRY_W = FLAG_WIDTH + PC_WIDTH;

  op_e                  op;
  logic                 push, pop;
  logic                 stack_clr;
  logic [ENTRY_W-1:0]   stack_top;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;

  // Strobe priority: only the highest-priority asserted strobe takes effect.
  always_comb begin
    op = OP_NONE;
    if      (initialize) op = OP_INIT;
    else if (interrupt)  op = OP_INT;
    else if (ex_call)    op = OP_CALL;
    else if (ex_ret_int) op = OP_RETI;
    else if (ex_ret_sub) op = OP_RETS;
    else if (ex_jump)    op = OP_JUMP;
    else if (fetch)      op = OP_FETCH;
  end

  // rst outranks every strobe, so it also suppresses the stack push/pop.
  assign push      = !rst && ((op == OP_INT) || (op == OP_CALL));
  assign pop       = !rst && ((op == OP_RETI) || (op == OP_RETS));
  assign stack_clr = rst || initialize;

  // Next-PC mux. A pop from an empty stack holds the PC; a push into a full
  // stack still loads its target, the stack itself just refuses the write.
  always_comb begin
    pc_d = pc_q;
    case (op)
      OP_INIT:  pc_d = RESET_VECTOR;
      OP_INT:   pc_d = INT_VECTOR;
      OP_CALL:  pc_d = jump_addr;
      OP_RETI,
      OP_RETS:  pc_d = stack_empty ? pc_q : stack_top[PC_WIDTH-1:0];
      OP_JUMP:  pc_d = jump_addr;
      OP_FETCH: pc_d = pc_q + PC_WIDTH'(1);
      default:  pc_d = pc_q;
    endcase
  end

  // Program counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  // pc already points past the current instruction, so it is the return address.
  lifo_stack #(
    .WIDTH (ENTRY_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst   (stack_clr),
    .push  (push),
    .pop   (pop),
    .din   ({flags_in, pc_q}),
    .top   (stack_top),
    .empty (stack_empty),
    .full  (stack_full),
    .err   (stack_err)
  );

  assign pc        = pc_q;
  assign flags_out = stack_top[ENTRY_W-1:PC_WIDTH];

endmodule

// File: tb/tb_pc_stack_unit.sv
// Bench for pc_stack_unit: a vector table of strobe patterns with expected
// post-edge state, plus a nested-call sequence for stack full/overflow.
module tb_pc_stack_unit;

  // Strobe bit positions inside an 8-bit strobe word.
  localparam logic [7:0] S_RST  = 8'h80;
  localparam logic [7:0] S_INIT = 8'h40;
  localparam logic [7:0] S_INT  = 8'h20;
  localparam logic [7:0] S_CALL = 8'h10;
  localparam logic [7:0] S_RETI = 8'h08;
  localparam logic [7:0] S_RETS = 8'h04;
  localparam logic [7:0] S_JUMP = 8'h02;
  localparam logic [7:0] S_FET  = 8'h01;

  typedef struct {
    logic [7:0] strb;
    logic [7:0] jaddr;
    logic [5:0] fin;
    logic [7:0] e_pc;
    logic       e_empty;
    logic       e_full;
    logic       e_err;
    logic       chk_f;
    logic [5:0] e_f;
    string      name;
  } vec_t;

  typedef struct {
    logic [7:0] pc;
    logic       empty;
    logic       full;
    logic       err;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, initialize, fetch, ex_jump, ex_call, ex_ret_sub, ex_ret_int, interrupt;
  logic [7:0] jump_addr;
  logic [5:0] flags_in;
  logic [7:0] pc;
  logic [5:0] flags_out;
  logic       stack_empty, stack_full, stack_err;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  pc_stack_unit dut (
    .clk         (clk),
    .rst         (rst),
    .initialize  (initialize),
    .fetch       (fetch),
    .ex_jump     (ex_jump),
    .ex_call     (ex_call),
    .ex_ret_sub  (ex_ret_sub),
    .ex_ret_int  (ex_ret_int),
    .interrupt   (interrupt),
    .jump_addr   (jump_addr),
    .flags_in    (flags_in),
    .pc          (pc),
    .flags_out   (flags_out),
    .stack_empty (stack_empty),
    .stack_full  (stack_full),
    .stack_err   (stack_err)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t v(input logic [7:0] strb, input logic [7:0] ja, input logic [5:0] fi,
                             input logic [7:0] epc, input logic ee, input logic ef, input logic er,
                             input logic cf, input logic [5:0] efl, input string nm);
    vec_t r;
    r.strb = strb; r.jaddr = ja; r.fin = fi; r.e_pc = epc;
    r.e_empty = ee; r.e_full = ef; r.e_err = er; r.chk_f = cf; r.e_f = efl; r.name = nm;
    return r;
  endfunction

  // Drive one cycle of strobes (entered just after a rising edge), optionally
  // check the combinational flags_out before the edge, then score the result.
  task automatic step(input vec_t t);
    exp_t e;
    {rst, initialize, interrupt, ex_call, ex_ret_int, ex_ret_sub, ex_jump, fetch} = t.strb;
    jump_addr = t.jaddr;
    flags_in  = t.fin;
    #1;
    if (t.chk_f) check({t.name, ".flags_out"}, 32'(flags_out), 32'(t.e_f));
    e.pc = t.e_pc; e.empty = t.e_empty; e.full = t.e_full; e.err = t.e_err; e.name = t.name;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({e.name, ".pc"},    32'(pc),          32'(e.pc));
    check({e.name, ".empty"}, 32'(stack_empty), 32'(e.empty));
    check({e.name, ".full"},  32'(stack_full),  32'(e.full));
    check({e.name, ".err"},   32'(stack_err),   32'(e.err));
    {rst, initialize, interrupt, ex_call, ex_ret_int, ex_ret_sub, ex_jump, fetch} = 8'h00;
  endtask

  initial begin
    {rst, initialize, interrupt, ex_call, ex_ret_int, ex_ret_sub, ex_jump, fetch} = 8'h00;
    jump_addr = 8'h00;
    flags_in  = 6'h00;

    //              strobes         jaddr  flags      pc     emp  full err  chkf flags      name
    vecs.push_back(v(S_RST,          8'h00, 6'h00,     8'h00, 1, 0, 0, 0, 6'h00,     "reset"));
    vecs.push_back(v(S_FET,          8'h00, 6'h00,     8'h01, 1, 0, 0, 0, 6'h00,     "fetch1"));
    vecs.push_back(v(S_FET,          8'h00, 6'h00,     8'h02, 1, 0, 0, 0, 6'h00,     "fetch2"));
    vecs.push_back(v(S_FET,          8'h00, 6'h00,     8'h03, 1, 0, 0, 0, 6'h00,     "fetch3"));
    vecs.push_back(v(S_JUMP,         8'h10, 6'h00,     8'h10, 1, 0, 0, 0, 6'h00,     "jump10"));
    vecs.push_back(v(S_CALL,         8'h40, 6'h00,     8'h40, 0, 0, 0, 0, 6'h00,     "call40"));
    vecs.push_back(v(S_RETS,         8'h00, 6'h00,     8'h10, 1, 0, 0, 0, 6'h00,     "rets"));
    vecs.push_back(v(S_JUMP,         8'h22, 6'h00,     8'h22, 1, 0, 0, 0, 6'h00,     "jump22"));
    vecs.push_back(v(S_INT,          8'h00, 6'b010101, 8'h01, 0, 0, 0, 0, 6'h00,     "irq"));
    vecs.push_back(v(S_RETI,         8'h00, 6'h00,     8'h22, 1, 0, 0, 1, 6'b010101, "reti"));
    vecs.push_back(v(S_JUMP,         8'h30, 6'h00,     8'h30, 1, 0, 0, 0, 6'h00,     "jump30"));
    vecs.push_back(v(S_RETS,         8'h00, 6'h00,     8'h30, 1, 0, 1, 0, 6'h00,     "underflow"));
    vecs.push_back(v(S_FET,          8'h00, 6'h00,     8'h31, 1, 0, 1, 0, 6'h00,     "err_sticky"));
    vecs.push_back(v(S_INIT,         8'h00, 6'h00,     8'h00, 1, 0, 0, 0, 6'h00,     "init"));
    vecs.push_back(v(S_JUMP,         8'hFF, 6'h00,     8'hFF, 1, 0, 0, 0, 6'h00,     "jumpFF"));
    vecs.push_back(v(S_FET,          8'h00, 6'h00,     8'h00, 1, 0, 0, 0, 6'h00,     "wrap"));
    vecs.push_back(v(S_INT | S_FET,  8'h00, 6'b000011, 8'h01, 0, 0, 0, 0, 6'h00,     "irq_fetch"));
    vecs.push_back(v(S_RETI,         8'h00, 6'h00,     8'h00, 1, 0, 0, 1, 6'b000011, "reti_pc0"));
    vecs.push_back(v(S_JUMP | S_FET, 8'h33, 6'h00,     8'h33, 1, 0, 0, 0, 6'h00,     "jump_fetch"));
    vecs.push_back(v(S_CALL | S_RETS | S_JUMP, 8'h50, 6'h2A, 8'h50, 0, 0, 0, 0, 6'h00, "call_wins"));
    vecs.push_back(v(S_RETI | S_JUMP, 8'h77, 6'h00,    8'h33, 1, 0, 0, 1, 6'h2A,     "reti_wins"));
    vecs.push_back(v(S_INIT | S_INT, 8'h00, 6'h00,     8'h00, 1, 0, 0, 0, 6'h00,     "init_wins"));
    vecs.push_back(v(S_JUMP,         8'h44, 6'h00,     8'h44, 1, 0, 0, 0, 6'h00,     "jump44"));
    vecs.push_back(v(S_RST | S_CALL, 8'h66, 6'h00,     8'h00, 1, 0, 0, 0, 6'h00,     "rst_wins"));
    vecs.push_back(v(S_RETS,         8'h00, 6'h00,     8'h00, 1, 0, 1, 0, 6'h00,     "no_push_on_rst"));
    vecs.push_back(v(S_INIT,         8'h00, 6'h00,     8'h00, 1, 0, 0, 0, 6'h00,     "init2"));

    @(posedge clk);
    #1;
    foreach (vecs[i]) step(vecs[i]);

    // Nested calls from A0 to 80..8F fill the stack; the 16th makes it full.
    step(v(S_JUMP, 8'hA0, 6'h00, 8'hA0, 1, 0, 0, 0, 6'h00, "jumpA0"));
    for (int i = 0; i < 16; i++)
      step(v(S_CALL, 8'(8'h80 + i), 6'h00, 8'(8'h80 + i), 0, (i == 15), 0, 0, 6'h00,
             $sformatf("nest%0d", i)));
    step(v(S_CALL, 8'h55, 6'h00, 8'h55, 0, 1, 1, 0, 6'h00, "overflow"));
    // Pops return 8E..80 then A0; the overflowing call pushed nothing.
    for (int k = 0; k < 16; k++)
      step(v(S_RETS, 8'h00, 6'h00, (k < 15) ? 8'(8'h8E - k) : 8'hA0, (k == 15), 0, 1, 0, 6'h00,
             $sformatf("unwind%0d", k)));
    step(v(S_INIT, 8'h00, 6'h00, 8'h00, 1, 0, 0, 0, 6'h00, "init_final"));

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
